// File: rtl/bist_stim_compactor_pkg.sv
// Shared types and constants for the BIST stimulus generator / compactor.
// Holds the FSM states, the register width and the feedback taps.
package bist_stim_compactor_pkg;

  localparam int LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] POLY_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] v,
    input logic              sin
  );
    return {v[LFSR_W-2:0], (^(v & POLY_TAPS)) ^ sin};
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci shift register with serial XOR input.
// Serves as pattern generator (sin = 0) or as signature register.
module bist_lfsr16
  import bist_stim_compactor_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = '0,
  parameter int                OUT_W   = LFSR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_val,
  input  logic              i_en,
  input  logic              i_sin,
  output logic [OUT_W-1:0]  o_q
);

  logic [LFSR_W-1:0] r_q;

  // Load has priority over shifting; reset returns to the fixed start value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= lfsr_step(r_q, i_sin);
    end
  end

  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/bist_stim_compactor.sv
// BIST controller: drives LFSR stimulus into a CUT and folds the
// latency-aligned responses into a MISR signature.
module bist_stim_compactor
  import bist_stim_compactor_pkg::*;
#(
  parameter int                PAT_COUNT = 1000,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                CUT_LAT   = 2
) (
  input  logic              I1470,
  input  logic              I1477,
  input  logic              start,
  input  logic              cut_resp,
  input  logic [LFSR_W-1:0] golden,
  output logic [3:0]        stim,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] signature,
  output logic              pass
);

  localparam logic [15:0] PAT_LAST = 16'(PAT_COUNT - 1);
  localparam logic [3:0]  FL_LAST  =
    (CUT_LAT == 0) ? 4'd0 : 4'(CUT_LAT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_fcnt;
  logic        r_stim_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_start_ok;
  logic        w_last;
  logic        w_gen_en;
  logic        w_misr_en;
  logic        w_qv;
  logic [3:0]  w_stim;
  logic [LFSR_W-1:0] w_misr_q;

  assign w_start_ok = start &&
    (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last    = (r_cnt == PAT_LAST);
  // Hold the last pattern through FLUSH: no step on the final RUN cycle.
  assign w_gen_en  = (r_state == ST_RUN) && !w_last;
  assign w_misr_en = w_qv && r_busy;

  // Run sequencing with registered status outputs.
  always_ff @(posedge I1470) begin
    if (!I1477) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_stim_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_fcnt       <= '0;
            r_stim_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_last) begin
            r_stim_valid <= 1'b0;
            if (CUT_LAT == 0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          r_fcnt <= r_fcnt + 4'd1;
          if (r_fcnt == FL_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    if (CUT_LAT == 0) begin : g_nodly
      assign w_qv = r_stim_valid;
    end else begin : g_dly
      logic [CUT_LAT-1:0] r_dly;

      // Align stim_valid with the CUT response latency.
      always_ff @(posedge I1470) begin
        if (!I1477 || w_start_ok) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= r_stim_valid;
          for (int i = 1; i < CUT_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_qv = r_dly[CUT_LAT-1];
    end
  endgenerate

  bist_lfsr16 #(
    .RST_VAL (LFSR_SEED),
    .OUT_W   (4)
  ) u_gen (
    .i_clk      (I1470),
    .i_rst_n    (I1477),
    .i_load     (w_start_ok),
    .i_load_val (LFSR_SEED),
    .i_en       (w_gen_en),
    .i_sin      (1'b0),
    .o_q        (w_stim)
  );

  bist_lfsr16 #(
    .RST_VAL ('0),
    .OUT_W   (LFSR_W)
  ) u_misr (
    .i_clk      (I1470),
    .i_rst_n    (I1477),
    .i_load     (w_start_ok),
    .i_load_val ('0),
    .i_en       (w_misr_en),
    .i_sin      (cut_resp),
    .o_q        (w_misr_q)
  );

  assign stim       = w_stim;
  assign stim_valid = r_stim_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign signature  = w_misr_q;
  assign pass       = r_done && (w_misr_q == golden);

endmodule

// File: tb/tb_bist_stim_compactor.sv
// Self-checking bench: three configurations, scoreboard of expected
// stimulus patterns and signatures against a software LFSR/MISR model.
module tb_bist_stim_compactor;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          NPAT = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        st_a = 1'b0, cr_a = 1'b0;
  logic [15:0] gd_a = 16'h0000;
  logic [3:0]  a_stim;
  logic        a_sv, a_busy, a_done, a_pass;
  logic [15:0] a_sig;

  logic        st_b = 1'b0, cr_b = 1'b0;
  logic [15:0] gd_b = 16'h0001;
  logic [3:0]  b_stim;
  logic        b_sv, b_busy, b_done, b_pass;
  logic [15:0] b_sig;

  logic        st_c = 1'b0;
  logic        cr_c;
  logic [15:0] gd_c = 16'h0000;
  logic [3:0]  c_stim;
  logic        c_sv, c_busy, c_done, c_pass;
  logic [15:0] c_sig;

  bist_stim_compactor #(.PAT_COUNT(4), .CUT_LAT(0)) u_a (
    .I1470(clk), .I1477(rst_n), .start(st_a), .cut_resp(cr_a),
    .golden(gd_a), .stim(a_stim), .stim_valid(a_sv), .busy(a_busy),
    .done(a_done), .signature(a_sig), .pass(a_pass)
  );

  bist_stim_compactor #(.PAT_COUNT(1), .CUT_LAT(2)) u_b (
    .I1470(clk), .I1477(rst_n), .start(st_b), .cut_resp(cr_b),
    .golden(gd_b), .stim(b_stim), .stim_valid(b_sv), .busy(b_busy),
    .done(b_done), .signature(b_sig), .pass(b_pass)
  );

  bist_stim_compactor u_c (
    .I1470(clk), .I1477(rst_n), .start(st_c), .cut_resp(cr_c),
    .golden(gd_c), .stim(c_stim), .stim_valid(c_sv), .busy(c_busy),
    .done(c_done), .signature(c_sig), .pass(c_pass)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  q_stim[$];
  logic [15:0] q_sig[$];

  function automatic logic [15:0] nxt(input logic [15:0] v,
                                      input logic sin);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ sin};
  endfunction

  function automatic logic cut_f(input logic [3:0] s);
    return s[0] ^ s[2] ^ (s[1] & s[3]);
  endfunction

  // Reference CUT: combinational function behind a 2-stage pipeline.
  logic cp1 = 1'b0, cp2 = 1'b0;
  always @(posedge clk) begin
    cp1 <= cut_f(c_stim);
    cp2 <= cp1;
  end
  assign cr_c = cp2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_run(output logic [3:0] last);
    logic [15:0] p, m;
    p = SEED;
    m = 16'h0000;
    last = 4'h0;
    for (int i = 0; i < NPAT; i++) begin
      q_stim.push_back(p[3:0]);
      m = nxt(m, cut_f(p[3:0]));
      last = p[3:0];
      p = nxt(p, 1'b0);
    end
    q_sig.push_back(m);
  endtask

  task automatic run_c(input bit disturb, output int busy_n,
                       output int sv_n, output logic [15:0] sig);
    logic [3:0]  last;
    logic [15:0] e;
    bit          fin;
    busy_n = 0;
    sv_n   = 0;
    fin    = 1'b0;
    push_run(last);
    @(negedge clk);
    st_c = 1'b1;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      st_c = disturb && (k == 500 || k == NPAT);
      if (c_sv) begin
        sv_n++;
        if (q_stim.size() == 0) chk("stim_extra", 1, 0);
        else chk("stim", c_stim, q_stim.pop_front());
      end
      if (c_busy) begin
        busy_n++;
        if (!c_sv) chk("stim_hold", c_stim, last);
      end
      if (c_done) fin = 1'b1;
    end
    st_c = 1'b0;
    if (!fin) chk("c_timeout", 0, 1);
    chk("stim_left", q_stim.size(), 0);
    q_stim.delete();
    e = (q_sig.size() != 0) ? q_sig.pop_front() : 16'hxxxx;
    sig = c_sig;
    chk("c_sig", c_sig, e);
    gd_c = e;
    #1;
    chk("c_pass", c_pass, 1);
  endtask

  initial begin
    int bn, sn, b2, s2;
    logic [15:0] s_ref, s_dis, s_ab;
    bit fin;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stim", c_stim, 4'h1);
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_sig", c_sig, 16'h0000);
    chk("rst_sv", c_sv, 0);
    chk("rst_pass", c_pass, 0);
    chk("rst_a_stim", a_stim, 4'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // PAT_COUNT=4, CUT_LAT=0, zero responses
    st_a = 1'b1;
    bn = 0;
    fin = 1'b0;
    for (int k = 0; k < 50 && !fin; k++) begin
      @(negedge clk);
      st_a = 1'b0;
      if (a_busy) bn++;
      if (a_done) fin = 1'b1;
    end
    chk("a_done", a_done, 1);
    chk("a_busy_len", bn, 4);
    chk("a_sig", a_sig, 16'h0000);
    gd_a = 16'h0000;
    #1;
    chk("a_pass1", a_pass, 1);
    gd_a = 16'h0001;
    #1;
    chk("a_pass0", a_pass, 0);

    // PAT_COUNT=1, CUT_LAT=2, response only in the qualified cycle
    @(negedge clk);
    st_b = 1'b1;
    bn = 0;
    fin = 1'b0;
    for (int k = 0; k < 50 && !fin; k++) begin
      @(negedge clk);
      st_b = 1'b0;
      cr_b = (k == 2);
      if (b_busy) bn++;
      if (b_done) fin = 1'b1;
    end
    cr_b = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_busy_len", bn, 3);
    chk("b_sig", b_sig, 16'h0001);
    #1;
    chk("b_pass", b_pass, 1);

    // Defaults, reference CUT in the loop
    run_c(1'b0, bn, sn, s_ref);
    chk("c_sv_len", sn, NPAT);
    chk("c_busy_len", bn, NPAT + 2);

    // start pulses during RUN and FLUSH must be ignored
    run_c(1'b1, b2, s2, s_dis);
    chk("dis_busy_len", b2, bn);
    chk("dis_sv_len", s2, sn);
    chk("dis_sig", s_dis, s_ref);

    // Reset mid-run, then a clean run
    @(negedge clk);
    st_c = 1'b1;
    @(negedge clk);
    st_c = 1'b0;
    repeat (300) @(negedge clk);
    chk("ab_busy_pre", c_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ab_busy", c_busy, 0);
    chk("ab_sv", c_sv, 0);
    chk("ab_done", c_done, 0);
    chk("ab_sig", c_sig, 16'h0000);
    chk("ab_stim", c_stim, 4'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ab_idle", c_busy, 0);
    run_c(1'b0, b2, s2, s_ab);
    chk("ab_sig_eq", s_ab, s_ref);
    chk("ab_busy_len", b2, bn);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bist_stim_compactor.md
BIST_STIM_COMPACTOR -- requirements
Module: bist_stim_compactor

Interface
REQ-001 Parameter PAT_COUNT, default 1000: number of stimulus patterns applied per run (legal 1..65535).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset and start value.
REQ-003 Parameter CUT_LAT, default 2: clock cycles from a stimulus change to the matching circuit-under-test (CUT) response (legal 0..7).
REQ-004 I1470  input  1  clock; all state updates on rising edge.
REQ-005 I1477  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle run request; honoured in IDLE or DONE only.
REQ-007 cut_resp  input  1  CUT response bit.
REQ-008 golden  input  16  expected signature; sampled only in DONE.
REQ-009 stim  output  4  CUT data stimulus (excludes CUT clock and reset).
REQ-010 stim_valid  output  1  high while stim carries a counted pattern.
REQ-011 busy  output  1  high in RUN or FLUSH.
REQ-012 done  output  1  high in DONE.
REQ-013 signature  output  16  MISR contents.
REQ-014 pass  output  1  done AND (signature == golden).

Function
REQ-015 FSM states: IDLE, RUN, FLUSH, DONE; the FSM is in IDLE after reset.
REQ-016 IDLE/DONE to RUN on start=1: load LFSR with LFSR_SEED, clear MISR, pattern counter and flush counter.
REQ-017 In RUN, the LFSR (Fibonacci, x^16+x^14+x^13+x^11+1, shifts toward MSB) advances once per cycle; stim = lfsr[3:0] and stim_valid = 1.
REQ-018 In RUN, the pattern counter increments each cycle; after PAT_COUNT patterns, move to FLUSH (or directly to DONE when CUT_LAT = 0).
REQ-019 In FLUSH, stim holds its last value, stim_valid = 0, and the FSM stays CUT_LAT cycles, then moves to DONE.
REQ-020 MISR compaction:
- Uses the same polynomial as the LFSR, with cut_resp XORed into bit 0.
- Compacts exactly PAT_COUNT responses: the first is taken CUT_LAT cycles after the first RUN cycle, the last in the final FLUSH cycle.
- Not updated in IDLE or DONE.
REQ-021 A delay line of CUT_LAT stages carries stim_valid to qualify MISR updates; samples without a qualified valid are ignored.
REQ-022 In DONE, signature holds until the next start; a start in DONE restarts per REQ-016.
REQ-023 start in RUN or FLUSH is ignored; the run completes unchanged.
REQ-024 Pattern counter is 16 bits and does not wrap within a run.
REQ-025 pass is combinational from golden and the registered signature, and is 0 outside DONE.

Reset
REQ-026 Reset (I1477 = 0 at a clock edge) values:
- FSM to IDLE; lfsr = LFSR_SEED; MISR = 0; counters and delay line = 0.
- Outputs: stim = LFSR_SEED[3:0], stim_valid = 0, busy = 0, done = 0, signature = 0, pass = 0.
REQ-027 Reset asserted mid-run aborts the run within one cycle; no partial signature is retained.

Structure
REQ-028 A shared package holds the FSM state enum, the LFSR/MISR polynomial tap constant and the 16-bit width constant.
REQ-029 One sub-module, bist_lfsr16, is instantiated twice:
- Inputs: load value, enable and serial XOR input.
- Used as the generator (serial input 0) and as the MISR (serial input cut_resp).

Verification
REQ-030 Reset with defaults -> stim = 4'h1, busy = 0, done = 0, signature = 16'h0000.
REQ-031 PAT_COUNT = 4, CUT_LAT = 0, cut_resp tied 0, start pulse -> busy high for exactly 4 cycles, then done = 1 and signature = 16'h0000; golden = 16'h0000 -> pass = 1, golden = 16'h0001 -> pass = 0.
REQ-032 PAT_COUNT = 1, CUT_LAT = 2, cut_resp = 1 only in the qualified sample cycle -> signature = 16'h0001, and busy lasts 3 cycles.
REQ-033 Defaults with cut_resp driven by a reference model of the CUT fed from stim -> signature matches the software MISR model bit-exactly, and stim_valid is high for exactly 1000 cycles.
REQ-034 start re-pulsed during RUN and during FLUSH -> cycle count and signature are identical to an undisturbed run.
REQ-035 I1477 driven low mid-RUN, then start -> second run signature equals a clean single run, and no carry-over from the aborted run.
